data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
//  Datapath of the 8-bit adding machine: instruction register (IR), accumulator (ACC),
//  6-bit program counter (PC), adder/pass ALU and address multiplexer.
//  Driven cycle-by-cycle by the controller FSM; every register updates on the rising clock.
//  Memory data enters on Data_bus_in; the memory address leaves on out_adr.
// PARAMETERS
//  DATA_W   8   data, IR, ACC and ALU width
//  ADR_W    6   PC and address width; IR[ADR_W-1:0] is the operand address
// PORTS
//  clock        in   1       single system clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  Data_bus_in  in   DATA_W  data from memory
//  load_IR      in   1       load IR from Data_bus_in
//  load_acc     in   1       load ACC from selected source
//  sel_alu      in   1       ACC source = ALU output
//  sel_bus      in   1       ACC source = Data_bus_in
//  pass_add     in   1       ALU op: 1 = add, 0 = pass
//  ld_pc        in   1       load PC from IR[ADR_W-1:0]
//  clr_pc       in   1       synchronous clear of PC
//  inc_pc       in   1       PC increment
//  ir_on_adr    in   1       drive IR address onto out_adr
//  pc_on_adr    in   1       drive PC onto out_adr
//  out_acc      out  DATA_W  ACC contents
//  out_IR       out  DATA_W  IR contents
//  out_PC       out  ADR_W   PC contents
//  out_ALU      out  DATA_W  combinational ALU result
//  out_adr      out  ADR_W   memory address
// BEHAVIOUR
//  - reset low (any time, even mid-cycle): ACC=0, IR=0, PC=0 immediately; controls ignored.
//  - IR: on the clock edge with load_IR=1, IR <= Data_bus_in; otherwise it holds.
//  - ALU (combinational): out_ALU = pass_add ? (ACC + Data_bus_in) mod 2^DATA_W : Data_bus_in.
//    Carry is dropped (FF+01 = 00).
//  - ACC: on the edge with load_acc=1, ACC <= sel_alu ? out_ALU : Data_bus_in.
//    sel_alu has priority over sel_bus; with neither set, Data_bus_in is loaded.
//    With load_acc=0, ACC holds regardless of sel_*.
//  - PC priority per edge: clr_pc > ld_pc > inc_pc > hold.
//    ld_pc loads IR[ADR_W-1:0]; inc_pc wraps 63 -> 0.
//    ld_pc and inc_pc together: load wins, no increment.
//  - out_adr (combinational): ir_on_adr ? IR[ADR_W-1:0] : pc_on_adr ? PC : 0.
//    IR has priority when both are set.
//  - Load latency: 1 clock. out_acc, out_IR and out_PC are direct register outputs.
//  - Simultaneous load_IR and ld_pc: PC takes the OLD IR address.
// CONFIGURATION
//  DATAPATH_CARRY_EN defined:
//    - adds output port carry_out (1 bit), a register.
//    - On a load_acc edge with sel_alu=1 and pass_add=1, carry_out <= carry of ACC+Data_bus_in.
//    - On any other load_acc edge, carry_out <= 0.
//    - Otherwise carry_out holds; reset clears it.
//  DATAPATH_CARRY_EN undefined: no carry_out port, carry is discarded.
// TESTING
//  1. reset low with Data_bus_in=FF and all loads high -> acc=00, IR=00, PC=00 while reset is low.
//  2. Data_bus_in=A5, load_IR one cycle -> out_IR=A5, out_acc unchanged;
//     then ir_on_adr=1 -> out_adr=25.
//  3. Data_bus_in=3C, load_acc with sel_bus -> acc=3C;
//     then bus=14, pass_add=1 -> out_ALU=50; load_acc with sel_alu -> acc=50.
//  4. acc=F0, bus=20, add+load -> acc=10 (wrap); carry_out=1 when DATAPATH_CARRY_EN is defined.
//  5. IR=A5, ld_pc and inc_pc together -> PC=25; inc_pc from 3F -> 00;
//     clr_pc together with ld_pc -> 00.
//  6. pc_on_adr=1 with PC=07 -> out_adr=07;
//     both ir_on_adr and pc_on_adr set -> IR address; neither set -> 00.

Source files
------------

// File: rtl/data_path.sv
// Datapath of the 8-bit adding machine: IR, ACC, PC, add/pass ALU and address mux.
// Optional registered carry output when DATAPATH_CARRY_EN is defined.
module data_path #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] Data_bus_in,
    input  logic              load_IR,
    input  logic              load_acc,
    input  logic              sel_alu,
    input  logic              sel_bus,
    input  logic              pass_add,
    input  logic              ld_pc,
    input  logic              clr_pc,
    input  logic              inc_pc,
    input  logic              ir_on_adr,
    input  logic              pc_on_adr,
    output logic [DATA_W-1:0] out_acc,
    output logic [DATA_W-1:0] out_IR,
    output logic [ADR_W-1:0]  out_PC,
    output logic [DATA_W-1:0] out_ALU,
    output logic [ADR_W-1:0]  out_adr
`ifdef DATAPATH_CARRY_EN
    ,
    output logic              carry_out
`endif
);

    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] acc_q;
    logic [ADR_W-1:0]  pc_q;
    logic [DATA_W-1:0] add_result;
    logic [DATA_W-1:0] acc_src;
    logic [ADR_W-1:0]  ir_adr;

    assign ir_adr = ir_q[ADR_W-1:0];

`ifdef DATAPATH_CARRY_EN
    logic add_carry;
    logic carry_q;
    assign {add_carry, add_result} = {1'b0, acc_q} + {1'b0, Data_bus_in};
`else
    assign add_result = acc_q + Data_bus_in;
`endif

    always_comb begin
        out_ALU = pass_add ? add_result : Data_bus_in;
    end

    // The bus is the fallback ACC source, so sel_bus only matters when sel_alu is low.
    always_comb begin
        acc_src = Data_bus_in;
        if (sel_alu)
            acc_src = out_ALU;
        else if (sel_bus)
            acc_src = Data_bus_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else if (load_IR) begin
            ir_q <= Data_bus_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (load_acc) begin
            acc_q <= acc_src;
        end
    end

    // ld_pc uses the IR value from before this edge, even if load_IR is also set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (clr_pc) begin
            pc_q <= '0;
        end else if (ld_pc) begin
            pc_q <= ir_adr;
        end else if (inc_pc) begin
            pc_q <= pc_q + {{(ADR_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef DATAPATH_CARRY_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else if (load_acc) begin
            carry_q <= sel_alu & pass_add & add_carry;
        end
    end

    assign carry_out = carry_q;
`endif

    always_comb begin
        out_adr = '0;
        if (ir_on_adr)
            out_adr = ir_adr;
        else if (pc_on_adr)
            out_adr = pc_q;
    end

    assign out_acc = acc_q;
    assign out_IR  = ir_q;
    assign out_PC  = pc_q;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: vector table driven through a scoreboard queue,
// plus hand-written async reset sequences. Handles DATAPATH_CARRY_EN either way.
module tb_data_path;

    typedef struct {
        logic [7:0] bus;
        logic [9:0] ctrl;
        logic [7:0] alu;
        logic [7:0] adr;
        logic [7:0] acc;
        logic [7:0] ir;
        logic [7:0] pc;
        logic       carry;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [7:0] data_bus_in;
    logic       load_ir, load_acc, sel_alu, sel_bus, pass_add;
    logic       ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr;
    logic [7:0] out_acc, out_ir, out_alu;
    logic [5:0] out_pc, out_adr;
    logic       carry_out;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[22];
    vec_t exp_q[$];
    vec_t cur;

    data_path dut (
        .clock      (clock),
        .reset      (reset),
        .Data_bus_in(data_bus_in),
        .load_IR    (load_ir),
        .load_acc   (load_acc),
        .sel_alu    (sel_alu),
        .sel_bus    (sel_bus),
        .pass_add   (pass_add),
        .ld_pc      (ld_pc),
        .clr_pc     (clr_pc),
        .inc_pc     (inc_pc),
        .ir_on_adr  (ir_on_adr),
        .pc_on_adr  (pc_on_adr),
        .out_acc    (out_acc),
        .out_IR     (out_ir),
        .out_PC     (out_pc),
        .out_ALU    (out_alu),
        .out_adr    (out_adr)
`ifdef DATAPATH_CARRY_EN
        ,
        .carry_out  (carry_out)
`endif
    );

`ifndef DATAPATH_CARRY_EN
    assign carry_out = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mkVec(input logic [7:0] bus, input logic [9:0] ctrl,
                                   input logic [7:0] alu, input logic [7:0] adr,
                                   input logic [7:0] acc, input logic [7:0] ir,
                                   input logic [7:0] pc, input logic carry);
        vec_t v;
        v.bus = bus; v.ctrl = ctrl; v.alu = alu; v.adr = adr;
        v.acc = acc; v.ir = ir; v.pc = pc; v.carry = carry;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ctrl bit order: load_IR load_acc sel_alu sel_bus pass_add ld_pc clr_pc inc_pc ir_on_adr pc_on_adr
    task automatic applyStimulus(input vec_t v);
        data_bus_in = v.bus;
        {load_ir, load_acc, sel_alu, sel_bus, pass_add,
         ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr} = v.ctrl;
        exp_q.push_back(v);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_acc"}, out_acc, 8'h00);
        checkOutput({tag, "_ir"}, out_ir, 8'h00);
        checkOutput({tag, "_pc"}, {2'b00, out_pc}, 8'h00);
`ifdef DATAPATH_CARRY_EN
        checkOutput({tag, "_carry"}, {7'd0, carry_out}, 8'h00);
`endif
    endtask

    initial begin
        //                bus    ctrl           alu    adr    acc    ir     pc     c
        vecs[0]  = mkVec(8'hA5, 10'b1000000000, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 1'b0);
        vecs[1]  = mkVec(8'h00, 10'b0000000010, 8'h00, 8'h25, 8'h00, 8'hA5, 8'h00, 1'b0);
        vecs[2]  = mkVec(8'h3C, 10'b0101000000, 8'h3C, 8'h00, 8'h3C, 8'hA5, 8'h00, 1'b0);
        vecs[3]  = mkVec(8'h14, 10'b0000100000, 8'h50, 8'h00, 8'h3C, 8'hA5, 8'h00, 1'b0);
        vecs[4]  = mkVec(8'h14, 10'b0110100000, 8'h50, 8'h00, 8'h50, 8'hA5, 8'h00, 1'b0);
        vecs[5]  = mkVec(8'hF0, 10'b0100000000, 8'hF0, 8'h00, 8'hF0, 8'hA5, 8'h00, 1'b0);
        vecs[6]  = mkVec(8'h20, 10'b0110100000, 8'h10, 8'h00, 8'h10, 8'hA5, 8'h00, 1'b1);
        vecs[7]  = mkVec(8'h77, 10'b0011100000, 8'h87, 8'h00, 8'h10, 8'hA5, 8'h00, 1'b1);
        vecs[8]  = mkVec(8'hFF, 10'b0111100000, 8'h0F, 8'h00, 8'h0F, 8'hA5, 8'h00, 1'b1);
        vecs[9]  = mkVec(8'h01, 10'b0101000000, 8'h01, 8'h00, 8'h01, 8'hA5, 8'h00, 1'b0);
        vecs[10] = mkVec(8'h00, 10'b0000010100, 8'h00, 8'h00, 8'h01, 8'hA5, 8'h25, 1'b0);
        vecs[11] = mkVec(8'h00, 10'b0000000101, 8'h00, 8'h25, 8'h01, 8'hA5, 8'h26, 1'b0);
        vecs[12] = mkVec(8'h00, 10'b0000011100, 8'h00, 8'h00, 8'h01, 8'hA5, 8'h00, 1'b0);
        vecs[13] = mkVec(8'hC7, 10'b1000010000, 8'hC7, 8'h00, 8'h01, 8'hC7, 8'h25, 1'b0);
        vecs[14] = mkVec(8'h00, 10'b0000010000, 8'h00, 8'h00, 8'h01, 8'hC7, 8'h07, 1'b0);
        vecs[15] = mkVec(8'h00, 10'b0000000001, 8'h00, 8'h07, 8'h01, 8'hC7, 8'h07, 1'b0);
        vecs[16] = mkVec(8'hEA, 10'b1000000000, 8'hEA, 8'h00, 8'h01, 8'hEA, 8'h07, 1'b0);
        vecs[17] = mkVec(8'h00, 10'b0000000011, 8'h00, 8'h2A, 8'h01, 8'hEA, 8'h07, 1'b0);
        vecs[18] = mkVec(8'h00, 10'b0000000000, 8'h00, 8'h00, 8'h01, 8'hEA, 8'h07, 1'b0);
        vecs[19] = mkVec(8'h3F, 10'b1000000000, 8'h3F, 8'h00, 8'h01, 8'h3F, 8'h07, 1'b0);
        vecs[20] = mkVec(8'h00, 10'b0000010000, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h3F, 1'b0);
        vecs[21] = mkVec(8'h00, 10'b0000000100, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h00, 1'b0);

        // Reset held low with every load active and an all-ones bus.
        reset       = 1'b0;
        data_bus_in = 8'hFF;
        {load_ir, load_acc, sel_alu, sel_bus, pass_add,
         ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr} = 10'b1111110100;
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset_hold");

        @(negedge clock);
        {load_ir, load_acc, sel_alu, sel_bus, pass_add,
         ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr} = 10'b0;
        data_bus_in = 8'h00;
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_alu", i), out_alu, exp_q[0].alu);
            checkOutput($sformatf("v%0d_adr", i), {2'b00, out_adr}, exp_q[0].adr);
            @(posedge clock);
            #1;
            cur = exp_q.pop_front();
            checkOutput($sformatf("v%0d_acc", i), out_acc, cur.acc);
            checkOutput($sformatf("v%0d_ir", i), out_ir, cur.ir);
            checkOutput($sformatf("v%0d_pc", i), {2'b00, out_pc}, cur.pc);
`ifdef DATAPATH_CARRY_EN
            checkOutput($sformatf("v%0d_carry", i), {7'd0, carry_out}, {7'd0, cur.carry});
`endif
        end

        // Load known non-zero state, then drop reset between edges.
        @(negedge clock);
        data_bus_in = 8'hFF;
        {load_ir, load_acc, sel_alu, sel_bus, pass_add,
         ld_pc, clr_pc, inc_pc, ir_on_adr, pc_on_adr} = 10'b1111100100;
        @(posedge clock);
        #1;
        checkOutput("preload_acc", out_acc, 8'h00);
        checkOutput("preload_ir", out_ir, 8'hFF);
        checkOutput("preload_pc", {2'b00, out_pc}, 8'h01);
`ifdef DATAPATH_CARRY_EN
        checkOutput("preload_carry", {7'd0, carry_out}, 8'h01);
`endif
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        @(posedge clock);
        #1;
        checkAllZero("async_reset_edge");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
